// File: rtl/trace_pkg.sv
// trace_pkg: shared constants for the trace run encoder.
// Packet layout is {run_start_pc, run_count[31:0]}; the count field sits at bit 0.
package trace_pkg;

  // Packet field offsets.
  localparam int unsigned RUN_PC_LSB  = 32;
  localparam int unsigned RUN_CNT_LSB = 0;

  // Encoder state encoding; these values are kept stable for existing tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default encoding of the instruction that ends the program.
  localparam logic [31:0] WFI_DEFAULT = 32'h0000_0001;

endpackage

// File: rtl/trace_pkt_slot.sv
// trace_pkt_slot: single-entry valid/ready holding register for run packets,
// plus a saturating counter of packets lost while the slot was busy.
// The encoder must present a last packet only when slot_free_o is high, so a
// last packet is never dropped here.
module trace_pkt_slot #(
  parameter int unsigned DW = 96
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          emit_valid_i,
  input  logic [DW-1:0] emit_data_i,
  input  logic          emit_last_i,
  input  logic          extra_drop_i,
  output logic          slot_free_o,
  output logic          pkt_valid_o,
  input  logic          pkt_ready_i,
  output logic [DW-1:0] pkt_data_o,
  output logic          pkt_last_o,
  output logic [31:0]   drop_count_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic [31:0]   drop_q, drop_d;
  logic [1:0]    drop_inc_s;
  logic [32:0]   drop_sum_s;

  // The slot may be loaded when empty or when its packet is leaving this cycle.
  assign slot_free_o = ~valid_q | pkt_ready_i;

  // Next-state for the holding register and the saturating drop counter.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    drop_inc_s = {1'b0, emit_valid_i & ~slot_free_o} + {1'b0, extra_drop_i};
    drop_sum_s = {1'b0, drop_q} + {31'd0, drop_inc_s};
    if (emit_valid_i && slot_free_o) begin
      valid_d = 1'b1;
      data_d  = emit_data_i;
      last_d  = emit_last_i;
    end else if (valid_q && pkt_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (drop_sum_s[32]) begin
      drop_d = 32'hFFFF_FFFF;
    end else begin
      drop_d = drop_sum_s[31:0];
    end
  end

  // Slot registers; data and last stay stable while waiting for the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= 32'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign pkt_valid_o  = valid_q;
  assign pkt_data_o   = data_q;
  assign pkt_last_o   = last_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/trace_run_encoder.sv
// trace_run_encoder: compresses the committed-instruction trace into run
// packets {run_start_pc, run_count}. A WFI closes the trace with a last packet.
// Build option: define TRACE_RVC_SEQ_EN to also treat pc == last_pc+2 as
// sequential (compressed instructions); by default only +4 continues a run.
module trace_run_encoder
  import trace_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] WFI_INSTR = WFI_DEFAULT
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    pc,
  input  logic [31:0]        instr,
  input  logic               pc_valid,
  input  logic               flush,
  output logic               pkt_valid,
  input  logic               pkt_ready,
  output logic [XLEN+32-1:0] pkt_data,
  output logic               pkt_last,
  output logic [31:0]        drop_count,
  output logic               finished
);

  localparam int unsigned      PKT_W   = XLEN + 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [XLEN-1:0]  STEP4   = XLEN'(4);
`ifdef TRACE_RVC_SEQ_EN
  localparam logic [XLEN-1:0]  STEP2   = XLEN'(2);
`endif

  // Build a packet from a run start PC and its (zero-extended) count.
  function automatic logic [PKT_W-1:0] make_pkt(input logic [XLEN-1:0]  start,
                                                input logic [CNT_W-1:0] cnt);
    logic [31:0]      cnt32;
    logic [PKT_W-1:0] p;
    cnt32 = 32'd0;
    cnt32[CNT_W-1:0] = cnt;
    p = '0;
    p[RUN_PC_LSB +: XLEN] = start;
    p[RUN_CNT_LSB +: 32]  = cnt32;
    return p;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  start_q, start_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_valid_q, pend_valid_d;
  logic [PKT_W-1:0] pend_data_q, pend_data_d;
  logic             finished_q, finished_d;

  logic             is_seq_s, is_wfi_s, take_s;
  logic             em_a_s, em_b_s, em_b_last_s;
  logic [XLEN-1:0]  new_start_s;
  logic [CNT_W-1:0] new_count_s;
  logic [PKT_W-1:0] em_a_data_s, em_b_data_s;
  logic             emit_valid_s, emit_last_s, extra_drop_s, slot_free_s;
  logic [PKT_W-1:0] emit_data_s;

  // Sequential-PC detection; the XLEN-wide add wraps naturally.
`ifdef TRACE_RVC_SEQ_EN
  assign is_seq_s = (pc == last_pc_q + STEP4) || (pc == last_pc_q + STEP2);
`else
  assign is_seq_s = (pc == last_pc_q + STEP4);
`endif
  assign is_wfi_s = (instr == WFI_INSTR);

  // Run tracking, emission decisions and routing into the slot / pending register.
  // em_a is the previously open run being closed; em_b is the run that includes
  // this cycle's beat, closed by WFI or flush.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    last_pc_d    = last_pc_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    finished_d   = finished_q;
    take_s       = 1'b0;
    em_a_s       = 1'b0;
    em_b_s       = 1'b0;
    em_b_last_s  = 1'b0;
    new_start_s  = start_q;
    new_count_s  = count_q;
    emit_valid_s = 1'b0;
    emit_data_s  = '0;
    emit_last_s  = 1'b0;
    extra_drop_s = 1'b0;

    if (pend_valid_q) begin
      // A held final packet: wait for the slot, then the trace is done.
      if (slot_free_s) begin
        emit_valid_s = 1'b1;
        emit_data_s  = pend_data_q;
        emit_last_s  = 1'b1;
        pend_valid_d = 1'b0;
        state_d      = ST_DONE;
        finished_d   = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pc_valid) begin
            take_s      = 1'b1;
            new_start_s = pc;
            new_count_s = CNT_ONE;
          end else begin
            take_s = 1'b0;
          end
        end
        ST_RUN: begin
          if (pc_valid) begin
            take_s = 1'b1;
            if (is_seq_s && (count_q != CNT_MAX)) begin
              new_count_s = count_q + CNT_ONE;
            end else begin
              em_a_s      = 1'b1;
              new_start_s = pc;
              new_count_s = CNT_ONE;
            end
          end else if (flush) begin
            em_a_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            take_s = 1'b0;
          end
        end
        ST_DONE: begin
          take_s = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (take_s) begin
        start_d   = new_start_s;
        count_d   = new_count_s;
        last_pc_d = pc;
        state_d   = ST_RUN;
        if (is_wfi_s) begin
          em_b_s      = 1'b1;
          em_b_last_s = 1'b1;
        end else if (flush) begin
          em_b_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          em_b_s = 1'b0;
        end
      end else begin
        take_s = 1'b0;
      end

      if (em_a_s) begin
        emit_valid_s = 1'b1;
        emit_data_s  = em_a_data_s;
        if (em_b_s && em_b_last_s) begin
          pend_valid_d = 1'b1;
          pend_data_d  = em_b_data_s;
        end else if (em_b_s) begin
          extra_drop_s = 1'b1;
        end else begin
          extra_drop_s = 1'b0;
        end
      end else if (em_b_s) begin
        if (!em_b_last_s) begin
          emit_valid_s = 1'b1;
          emit_data_s  = em_b_data_s;
        end else if (slot_free_s) begin
          emit_valid_s = 1'b1;
          emit_data_s  = em_b_data_s;
          emit_last_s  = 1'b1;
          state_d      = ST_DONE;
          finished_d   = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_data_d  = em_b_data_s;
        end
      end else begin
        emit_valid_s = 1'b0;
      end
    end
  end

  assign em_a_data_s = make_pkt(start_q, count_q);
  assign em_b_data_s = make_pkt(new_start_s, new_count_s);

  // Encoder state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= '0;
      last_pc_q    <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      last_pc_q    <= last_pc_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      finished_q   <= finished_d;
    end
  end

  trace_pkt_slot #(.DW(PKT_W)) u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .emit_valid_i (emit_valid_s),
    .emit_data_i  (emit_data_s),
    .emit_last_i  (emit_last_s),
    .extra_drop_i (extra_drop_s),
    .slot_free_o  (slot_free_s),
    .pkt_valid_o  (pkt_valid),
    .pkt_ready_i  (pkt_ready),
    .pkt_data_o   (pkt_data),
    .pkt_last_o   (pkt_last),
    .drop_count_o (drop_count)
  );

  assign finished = finished_q;

endmodule

// File: tb/tb_trace_run_encoder.sv
// Directed bench for trace_run_encoder: a default instance (CNT_W=32) and a
// CNT_W=4 instance share the same stimulus; the small one is checked for
// run-length saturation.
module tb_trace_run_encoder;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        pc_valid;
  logic        flush;
  logic        pkt_ready;

  logic        pkt_valid,  pkt_last,  finished;
  logic [95:0] pkt_data;
  logic [31:0] drop_count;
  logic        pkt_valid4, pkt_last4, finished4;
  logic [95:0] pkt_data4;
  logic [31:0] drop_count4;

  int checks   = 0;
  int failures = 0;

  trace_run_encoder #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .pc_valid(pc_valid),
    .flush(flush), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .pkt_last(pkt_last), .drop_count(drop_count),
    .finished(finished)
  );

  trace_run_encoder #(.XLEN(64), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .pc_valid(pc_valid),
    .flush(flush), .pkt_valid(pkt_valid4), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data4), .pkt_last(pkt_last4), .drop_count(drop_count4),
    .finished(finished4)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] exp_pkt(input logic [63:0] spc, input logic [31:0] cnt);
    return {spc, cnt};
  endfunction

  // One clock with the given inputs; returns #1 after the edge.
  task automatic beat(input logic [63:0] p, input logic [31:0] ins, input logic v, input logic f);
    pc = p; instr = ins; pc_valid = v; flush = f;
    @(posedge clk); #1;
    pc_valid = 1'b0; flush = 1'b0; instr = 32'h0000_0013;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pc_valid = 1'b0; flush = 1'b0; pc = 64'd0; instr = 32'h0000_0013;
    pkt_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WFI = 32'h0000_0001;

  initial begin
    // Reset values.
    do_reset();
    check_eq("rst_valid", {127'd0, pkt_valid}, 128'd0);
    check_eq("rst_data",  {32'd0, pkt_data}, 128'd0);
    check_eq("rst_last",  {127'd0, pkt_last}, 128'd0);
    check_eq("rst_drop",  {96'd0, drop_count}, 128'd0);
    check_eq("rst_fin",   {127'd0, finished}, 128'd0);

    // Sequential run broken by a jump.
    beat(64'h1000, NOP, 1'b1, 1'b0);
    beat(64'h1004, NOP, 1'b1, 1'b0);
    beat(64'h1008, NOP, 1'b1, 1'b0);
    check_eq("seq_no_pkt", {127'd0, pkt_valid}, 128'd0);
    beat(64'h2000, NOP, 1'b1, 1'b0);
    check_eq("seq_valid", {127'd0, pkt_valid}, 128'd1);
    check_eq("seq_data",  {32'd0, pkt_data}, {32'd0, exp_pkt(64'h1000, 32'd3)});
    check_eq("seq_last",  {127'd0, pkt_last}, 128'd0);
    idle(1);
    check_eq("seq_taken", {127'd0, pkt_valid}, 128'd0);

    // WFI ends the program.
    do_reset();
    beat(64'h3000, NOP, 1'b1, 1'b0);
    beat(64'h3004, NOP, 1'b1, 1'b0);
    beat(64'h3008, NOP, 1'b1, 1'b0);
    beat(64'h300C, WFI, 1'b1, 1'b0);
    check_eq("wfi_valid", {127'd0, pkt_valid}, 128'd1);
    check_eq("wfi_data",  {32'd0, pkt_data}, {32'd0, exp_pkt(64'h3000, 32'd4)});
    check_eq("wfi_last",  {127'd0, pkt_last}, 128'd1);
    check_eq("wfi_fin",   {127'd0, finished}, 128'd1);
    idle(1);
    beat(64'h5000, NOP, 1'b1, 1'b0);
    beat(64'h6000, NOP, 1'b1, 1'b0);
    beat(64'h7000, NOP, 1'b1, 1'b1);
    check_eq("done_quiet", {127'd0, pkt_valid}, 128'd0);
    check_eq("done_fin",   {127'd0, finished}, 128'd1);

    // Backpressure: first packet held, later ones dropped.
    do_reset();
    pkt_ready = 1'b0;
    beat(64'h100, NOP, 1'b1, 1'b0);
    beat(64'h200, NOP, 1'b1, 1'b0);
    beat(64'h300, NOP, 1'b1, 1'b0);
    beat(64'h400, NOP, 1'b1, 1'b0);
    check_eq("bp_valid", {127'd0, pkt_valid}, 128'd1);
    check_eq("bp_data",  {32'd0, pkt_data}, {32'd0, exp_pkt(64'h100, 32'd1)});
    check_eq("bp_drop",  {96'd0, drop_count}, 128'd2);
    idle(2);
    check_eq("bp_hold",  {32'd0, pkt_data}, {32'd0, exp_pkt(64'h100, 32'd1)});
    pkt_ready = 1'b1;
    idle(1);
    check_eq("bp_one",   {127'd0, pkt_valid}, 128'd0);
    idle(1);
    check_eq("bp_empty", {127'd0, pkt_valid}, 128'd0);
    // Reset while a packet is waiting discards it.
    pkt_ready = 1'b0;
    beat(64'h900, NOP, 1'b1, 1'b0);
    check_eq("bp_pend", {127'd0, pkt_valid}, 128'd1);
    do_reset();
    check_eq("rst_mid_valid", {127'd0, pkt_valid}, 128'd0);
    check_eq("rst_mid_drop",  {96'd0, drop_count}, 128'd0);

    // Saturation on the CNT_W=4 instance: 16 sequential pcs from 0.
    for (int i = 0; i < 16; i++) begin
      beat(64'(i * 4), NOP, 1'b1, 1'b0);
    end
    check_eq("sat_valid", {127'd0, pkt_valid4}, 128'd1);
    check_eq("sat_data",  {32'd0, pkt_data4}, {32'd0, exp_pkt(64'h0, 32'd15)});
    check_eq("sat_wide_quiet", {127'd0, pkt_valid}, 128'd0);
    beat(64'h0, NOP, 1'b0, 1'b1);
    check_eq("sat_newrun", {32'd0, pkt_data4}, {32'd0, exp_pkt(64'h3C, 32'd1)});
    check_eq("sat_wide",   {32'd0, pkt_data}, {32'd0, exp_pkt(64'h0, 32'd16)});

    // Flush mid-run, then a fresh run.
    do_reset();
    beat(64'h4000, NOP, 1'b1, 1'b0);
    beat(64'h4004, NOP, 1'b1, 1'b0);
    beat(64'h0, NOP, 1'b0, 1'b1);
    check_eq("fl_valid", {127'd0, pkt_valid}, 128'd1);
    check_eq("fl_data",  {32'd0, pkt_data}, {32'd0, exp_pkt(64'h4000, 32'd2)});
    check_eq("fl_last",  {127'd0, pkt_last}, 128'd0);
    idle(1);
    beat(64'h0, NOP, 1'b0, 1'b1);
    check_eq("fl_idle", {127'd0, pkt_valid}, 128'd0);
    beat(64'h5000, NOP, 1'b1, 1'b0);
    beat(64'h6000, NOP, 1'b1, 1'b0);
    check_eq("fl_next", {32'd0, pkt_data}, {32'd0, exp_pkt(64'h5000, 32'd1)});

    // +2 step: sequential only with compressed-instruction support.
    do_reset();
    beat(64'h1000, NOP, 1'b1, 1'b0);
    beat(64'h1002, NOP, 1'b1, 1'b0);
`ifdef TRACE_RVC_SEQ_EN
    check_eq("rvc_quiet", {127'd0, pkt_valid}, 128'd0);
    beat(64'h0, NOP, 1'b0, 1'b1);
    check_eq("rvc_data", {32'd0, pkt_data}, {32'd0, exp_pkt(64'h1000, 32'd2)});
`else
    check_eq("rvc_data", {32'd0, pkt_data}, {32'd0, exp_pkt(64'h1000, 32'd1)});
    beat(64'h0, NOP, 1'b0, 1'b1);
    check_eq("rvc_next", {32'd0, pkt_data}, {32'd0, exp_pkt(64'h1002, 32'd1)});
`endif

    // Non-sequential WFI: old run first, WFI run follows as the last packet.
    do_reset();
    beat(64'h7000, NOP, 1'b1, 1'b0);
    beat(64'h7004, NOP, 1'b1, 1'b0);
    beat(64'h9000, WFI, 1'b1, 1'b0);
    check_eq("nsw_data1", {32'd0, pkt_data}, {32'd0, exp_pkt(64'h7000, 32'd2)});
    check_eq("nsw_last1", {127'd0, pkt_last}, 128'd0);
    check_eq("nsw_fin1",  {127'd0, finished}, 128'd0);
    idle(1);
    check_eq("nsw_valid2", {127'd0, pkt_valid}, 128'd1);
    check_eq("nsw_data2",  {32'd0, pkt_data}, {32'd0, exp_pkt(64'h9000, 32'd1)});
    check_eq("nsw_last2",  {127'd0, pkt_last}, 128'd1);
    check_eq("nsw_fin2",   {127'd0, finished}, 128'd1);

    // PC wrap-around is still sequential.
    do_reset();
    beat(64'hFFFF_FFFF_FFFF_FFFC, NOP, 1'b1, 1'b0);
    beat(64'h0, NOP, 1'b1, 1'b0);
    beat(64'h0, NOP, 1'b0, 1'b1);
    check_eq("wrap_data", {32'd0, pkt_data}, {32'd0, exp_pkt(64'hFFFF_FFFF_FFFF_FFFC, 32'd2)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
